regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 58 +++++
 tb/tb_regfile_mp.sv | 106 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address type and read-select helper for regfile_mp
package regfile_pkg;
  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_NUMREGS = 32;
  localparam int DEF_NREAD = 2;
  typedef logic [6:0] addr_t;
  localparam addr_t ZERO_ADDR = '0;
  typedef enum logic [1:0] {SEL_ZERO, SEL_BYPASS, SEL_ARRAY} rd_sel_e;
  function automatic logic addr_ok(addr_t a, addr_t nregs, logic zero);
    return a < nregs && !(zero && a == ZERO_ADDR);
  endfunction
  function automatic rd_sel_e rd_sel(addr_t ra, addr_t wa, logic wr, addr_t nregs, logic zero);
    return !addr_ok(ra, nregs, zero) ? SEL_ZERO : (wr && ra == wa) ? SEL_BYPASS : SEL_ARRAY;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with reserve-wins update and registered lookups
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUMREGS = DEF_NUMREGS,
  parameter int ADDRWIDTH = $clog2(NUMREGS),
  parameter int NREAD = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  input logic set,
  input logic [ADDRWIDTH-1:0] set_reg,
  input logic clr,
  input logic [ADDRWIDTH-1:0] clr_reg,
  input logic [NREAD*ADDRWIDTH-1:0] rd_reg,
  output logic [NREAD-1:0] rd_pending
);
  localparam addr_t NR = addr_t'(NUMREGS);
  localparam logic ZR = ZERO_REG != 0;
  logic [NUMREGS-1:0] pend, pend_nxt;
  // set is applied after clr so a new producer overrides a same-cycle writeback
  always_comb begin
    pend_nxt = pend;
    if (clr) pend_nxt[clr_reg] = 1'b0;
    if (set) pend_nxt[set_reg] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      rd_pending <= '0;
    end else begin
      pend <= pend_nxt;
      for (int k = 0; k < NREAD; k++)
        rd_pending[k] <= addr_ok(addr_t'(rd_reg[k*ADDRWIDTH +: ADDRWIDTH]), NR, ZR) &&
                         pend_nxt[rd_reg[k*ADDRWIDTH +: ADDRWIDTH]];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, optional zero register
// and per-register pending bits for decode stalls
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUMREGS = DEF_NUMREGS,
  parameter int ADDRWIDTH = $clog2(NUMREGS),
  parameter int NREAD = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  input logic write,
  input logic [ADDRWIDTH-1:0] writeReg,
  input logic [DATAWIDTH-1:0] writeData,
  input logic [NREAD*ADDRWIDTH-1:0] readReg,
  output logic [NREAD*DATAWIDTH-1:0] readData,
  output logic [NREAD-1:0] readPending,
  input logic reserve,
  input logic [ADDRWIDTH-1:0] reserveReg
);
  localparam addr_t NR = addr_t'(NUMREGS);
  localparam logic ZR = ZERO_REG != 0;
  logic [DATAWIDTH-1:0] regs [NUMREGS];
  logic [NREAD*DATAWIDTH-1:0] rd_nxt;
  logic wr_ok, rs_ok;
  assign wr_ok = write && addr_ok(addr_t'(writeReg), NR, ZR);
  assign rs_ok = reserve && addr_ok(addr_t'(reserveReg), NR, ZR);
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDRWIDTH-1:0] ra;
    rd_sel_e s;
    assign ra = readReg[k*ADDRWIDTH +: ADDRWIDTH];
    assign s = rd_sel(addr_t'(ra), addr_t'(writeReg), wr_ok, NR, ZR);
    assign rd_nxt[k*DATAWIDTH +: DATAWIDTH] = s == SEL_ZERO ? '0 : s == SEL_BYPASS ? writeData : regs[ra];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
      readData <= '0;
    end else begin
      if (wr_ok) regs[writeReg] <= writeData;
      readData <= rd_nxt;
    end
  end
  regfile_scoreboard #(
    .NUMREGS(NUMREGS), .ADDRWIDTH(ADDRWIDTH), .NREAD(NREAD), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .set(rs_ok),
    .set_reg(reserveReg),
    .clr(wr_ok),
    .clr_reg(writeReg),
    .rd_reg(readReg),
    .rd_pending(readPending)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for a default instance and a 24-reg, 4-port, no-zero-reg instance
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, write, reserve;
  logic [4:0] wreg, sreg;
  logic [31:0] wdata;
  logic [4:0] ra [4];
  logic [9:0] rr_a;
  logic [19:0] rr_b;
  logic [63:0] rd_a;
  logic [1:0] rp_a;
  logic [127:0] rd_b;
  logic [3:0] rp_b;
  assign rr_a = {ra[1], ra[0]};
  assign rr_b = {ra[3], ra[2], ra[1], ra[0]};
  regfile_mp u_a (
    .clk(clk), .rst(rst), .write(write), .writeReg(wreg), .writeData(wdata),
    .readReg(rr_a), .readData(rd_a), .readPending(rp_a), .reserve(reserve), .reserveReg(sreg)
  );
  regfile_mp #(.NUMREGS(24), .NREAD(4), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .write(write), .writeReg(wreg), .writeData(wdata),
    .readReg(rr_b), .readData(rd_b), .readPending(rp_b), .reserve(reserve), .reserveReg(sreg)
  );
  typedef struct packed {
    logic [1:0][3:0][31:0] d;
    logic [1:0][3:0] p;
  } exp_t;
  exp_t q [$];
  logic [31:0] mem [2][32];
  logic pnd [2][32];
  int nregs [2] = '{32, 24};
  bit zr [2] = '{1'b1, 1'b0};
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit ok(int d, int a);
    return a < nregs[d] && !(zr[d] && a == 0);
  endfunction
  task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                      input bit rs, input int sa, input int a0, input int a1, input int a2, input int a3);
    exp_t e;
    rst = r; write = w; wreg = 5'(wa); wdata = wd; reserve = rs; sreg = 5'(sa);
    ra[0] = 5'(a0); ra[1] = 5'(a1); ra[2] = 5'(a2); ra[3] = 5'(a3);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int i = 0; i < 32; i++) begin
          mem[d][i] = '0;
          pnd[d][i] = 1'b0;
        end
      end else begin
        if (w && ok(d, wa)) begin
          mem[d][wa] = wd;
          pnd[d][wa] = 1'b0;
        end
        if (rs && ok(d, sa)) pnd[d][sa] = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        e.d[d][k] = (!r && int'(ra[k]) < nregs[d]) ? mem[d][ra[k]] : 32'h0;
        e.p[d][k] = (!r && int'(ra[k]) < nregs[d]) ? pnd[d][ra[k]] : 1'b0;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("a.data%0d", k), rd_a[k*32 +: 32], e.d[0][k]);
      check($sformatf("a.pend%0d", k), 32'(rp_a[k]), 32'(e.p[0][k]));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b.data%0d", k), rd_b[k*32 +: 32], e.d[1][k]);
      check($sformatf("b.pend%0d", k), 32'(rp_b[k]), 32'(e.p[1][k]));
    end
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'h1, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, i, 31 - i, i, 31 - i);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 6, 5, 6);
    step(0, 0, 0, 0, 0, 0, 5, 6, 5, 6);
    step(0, 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 7, 7, 7, 7);
    step(0, 1, 7, 32'hA5, 0, 0, 7, 7, 7, 7);
    step(0, 1, 7, 32'h5A, 1, 7, 7, 7, 7, 7);
    step(0, 0, 0, 0, 0, 0, 7, 5, 7, 5);
    step(0, 1, 30, 32'hFF, 1, 30, 30, 30, 30, 30);
    step(0, 0, 0, 0, 0, 0, 30, 23, 30, 22);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, 0, 0, i, 23 - i, i, 23 - i);
    step(0, 1, 3, 32'h77, 1, 4, 3, 4, 3, 4);
    step(1, 1, 3, 32'h55, 1, 4, 3, 4, 3, 3);
    step(0, 0, 0, 0, 0, 0, 3, 4, 3, 3);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
